// File: rtl/sprite_scheduler.sv
// Per-pixel sprite arbiter: picks the highest-priority sprite covering (DrawX, DrawY),
// drives the shared sprite ROM and returns the palette index two cycles later.
module sprite_scheduler #(
  parameter int NUM_SPRITES     = 4,
  parameter int SPR_W           = 20,
  parameter int SPR_H           = 20,
  parameter int ADDR_W          = 9,
  parameter int SEL_W           = 2,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  input  logic              cfg_en,
  output logic [ADDR_W-1:0] rom_address,
  output logic [SEL_W-1:0]  rom_sel,
  input  logic [7:0]        rom_q,
  output logic              pix_valid,
  output logic [7:0]        pix_index,
  output logic [SEL_W-1:0]  pix_sprite,
  output logic              blank_out,
  output logic              collision
);

  logic [9:0]             sh_x   [NUM_SPRITES];
  logic [9:0]             sh_y   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en;
  logic [9:0]             act_x  [NUM_SPRITES];
  logic [9:0]             act_y  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_en;

  logic [NUM_SPRITES-1:0] hit;
  logic                   any_hit;
  logic [SEL_W-1:0]       sel;
  logic [10:0]            dx;
  logic [10:0]            dy;
  logic [ADDR_W-1:0]      offs;
  logic                   coll_set;
  logic                   coll_acc;
  logic                   hit_d;
  logic                   blank_d;

  // Active copy is loaded from the pre-write shadow, so a same-cycle write waits a frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_en  <= '0;
      act_en <= '0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
        end
        act_en <= sh_en;
      end
      if (cfg_we) begin
        sh_x[cfg_sel]  <= cfg_x;
        sh_y[cfg_sel]  <= cfg_y;
        sh_en[cfg_sel] <= cfg_en;
      end
    end
  end

  // 11-bit bounds so a box hanging past column 1023 is clipped instead of wrapping.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit[i] = act_en[i]
            && ({1'b0, DrawX} >= {1'b0, act_x[i]})
            && ({1'b0, DrawX} <  ({1'b0, act_x[i]} + 11'(SPR_W)))
            && ({1'b0, DrawY} >= {1'b0, act_y[i]})
            && ({1'b0, DrawY} <  ({1'b0, act_y[i]} + 11'(SPR_H)));
    end
  end

  always_comb begin
    sel = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
    any_hit  = |hit;
    dx       = {1'b0, DrawX} - {1'b0, act_x[sel]};
    dy       = {1'b0, DrawY} - {1'b0, act_y[sel]};
    offs     = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    coll_set = blank && hit[0] && (|hit[NUM_SPRITES-1:1]);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      rom_sel     <= '0;
      hit_d       <= 1'b0;
      blank_d     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_index   <= '0;
      pix_sprite  <= '0;
      blank_out   <= 1'b0;
    end else begin
      rom_address <= any_hit ? offs : '0;
      rom_sel     <= any_hit ? sel : '0;
      hit_d       <= any_hit;
      blank_d     <= blank;
      // rom_q was fetched on the intervening falling edge from the stage-1 address.
      pix_index   <= rom_q;
      pix_sprite  <= rom_sel;
      pix_valid   <= hit_d && blank_d && (rom_q != 8'(TRANSPARENT_IDX));
      blank_out   <= blank_d;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= coll_acc || coll_set;
      coll_acc  <= 1'b0;
    end else if (coll_set) begin
      coll_acc  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: directed table, corner sequences and a randomized run
// checked against a box/priority model and a memory-backed ROM.
module tb_sprite_scheduler;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, cfg_x, cfg_y;
  logic       blank, frame_start, cfg_we, cfg_en;
  logic [1:0] cfg_sel, rom_sel, pix_sprite;
  logic [8:0] rom_address;
  logic [7:0] rom_q, pix_index;
  logic       pix_valid, blank_out, collision;

  sprite_scheduler dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .rom_address(rom_address),
    .rom_sel(rom_sel), .rom_q(rom_q), .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_sprite(pix_sprite), .blank_out(blank_out), .collision(collision)
  );

  always #5 vga_clk = ~vga_clk;

  logic [7:0] rom_mem [4][512];
  always @(negedge vga_clk) rom_q <= rom_mem[rom_sel][rom_address];

  typedef struct { bit hit; int sel; int addr; bit bl; bit coll; } pred_t;
  typedef struct { int x; int y; bit bl; int e_addr; int e_sel; bit e_pv; int e_idx; } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    m_sh_x[4], m_sh_y[4], m_act_x[4], m_act_y[4];
  bit    m_sh_en[4], m_act_en[4];
  bit    m_acc, m_coll, p2_ok;
  pred_t prev;
  vec_t  tab[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pred_t predict(int x, int y, bit bl);
    pred_t p;
    bit    h[4];
    p = '{default: 0};
    p.bl = bl;
    for (int i = 0; i < 4; i++) begin
      h[i] = m_act_en[i] && x >= m_act_x[i] && x < m_act_x[i] + 20
             && y >= m_act_y[i] && y < m_act_y[i] + 20;
      if (h[i] && !p.hit) begin
        p.hit  = 1;
        p.sel  = i;
        p.addr = ((y - m_act_y[i]) * 20 + (x - m_act_x[i])) % 512;
      end
    end
    p.coll = bl && h[0] && (h[1] || h[2] || h[3]);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_en[i] = 0;
      m_act_x[i] = 0; m_act_y[i] = 0; m_act_en[i] = 0;
    end
    m_acc = 0; m_coll = 0; p2_ok = 0;
  endtask

  // One pixel clock: drive, predict from pre-edge state, update model, check outputs.
  task automatic cycle(int x, int y, bit bl, bit fs = 0, bit we = 0,
                       int ws = 0, int wx = 0, int wy = 0, bit wen = 0);
    pred_t p;
    int    idx, exp_addr, exp_sel;
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
    cfg_we = we; cfg_sel = 2'(ws); cfg_x = 10'(wx); cfg_y = 10'(wy); cfg_en = wen;
    p = predict(x, y, bl);
    @(posedge vga_clk);
    #1;
    if (fs) begin
      for (int i = 0; i < 4; i++) begin
        m_act_x[i] = m_sh_x[i]; m_act_y[i] = m_sh_y[i]; m_act_en[i] = m_sh_en[i];
      end
      m_coll = m_acc || p.coll;
      m_acc  = 0;
    end else if (p.coll) m_acc = 1;
    if (we) begin
      m_sh_x[ws] = wx; m_sh_y[ws] = wy; m_sh_en[ws] = wen;
    end
    exp_addr = p.hit ? p.addr : 0;
    exp_sel  = p.hit ? p.sel : 0;
    chk("rom_address", 32'(rom_address), 32'(exp_addr));
    chk("rom_sel", 32'(rom_sel), 32'(exp_sel));
    if (p2_ok) begin
      idx = int'(rom_mem[prev.hit ? prev.sel : 0][prev.hit ? prev.addr : 0]);
      chk("pix_index", 32'(pix_index), 32'(idx));
      chk("pix_valid", 32'(pix_valid), 32'(prev.hit && prev.bl && idx != 0));
      chk("pix_sprite", 32'(pix_sprite), 32'(prev.hit ? prev.sel : 0));
      chk("blank_out", 32'(blank_out), 32'(prev.bl));
    end
    chk("collision", 32'(collision), 32'(m_coll));
    prev  = p;
    p2_ok = 1;
    frame_start = 0; cfg_we = 0;
  endtask

  task automatic cfg(int s, int x, int y, bit en);
    cycle(0, 0, 0, 0, 1, s, x, y, en);
  endtask

  task automatic frame();
    cycle(0, 0, 0, 1);
  endtask

  initial begin
    reset_n = 0;
    DrawX = 0; DrawY = 0; blank = 0; frame_start = 0;
    cfg_we = 0; cfg_sel = 0; cfg_x = 0; cfg_y = 0; cfg_en = 0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 512; a++)
        rom_mem[s][a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rom_mem[0][45] = 8'h07;  rom_mem[2][110] = 8'h33; rom_mem[3][6] = 8'h44;
    rom_mem[0][0]  = 8'h11;  rom_mem[0][399] = 8'h00; rom_mem[1][25] = 8'h21;
    rom_mem[0][205] = 8'h55;
    model_reset();
    #2;
    chk("reset rom_address", 32'(rom_address), 0);
    chk("reset pix_valid", 32'(pix_valid), 0);
    chk("reset collision", 32'(collision), 0);
    #20 reset_n = 1;

    // Config A: s0 (100,50), s1 (300,300), s2 (190,195), s3 (1015,400)
    cfg(0, 100, 50, 1); cfg(1, 300, 300, 1); cfg(2, 190, 195, 1); cfg(3, 1015, 400, 1);
    frame();

    tab[0] = '{105, 52, 1, 45, 0, 1, 8'h07};
    tab[1] = '{200, 200, 1, 110, 2, 1, 8'h33};
    tab[2] = '{1021, 400, 1, 6, 3, 1, 8'h44};
    tab[3] = '{3, 400, 1, 0, 0, 0, 8'h11};
    tab[4] = '{119, 69, 1, 399, 0, 0, 8'h00};
    tab[5] = '{120, 69, 1, 0, 0, 0, 8'h11};
    tab[6] = '{105, 52, 0, 45, 0, 0, 8'h07};
    tab[7] = '{305, 301, 1, 25, 1, 1, 8'h21};
    for (int i = 0; i < 8; i++) begin
      cycle(tab[i].x, tab[i].y, tab[i].bl);
      chk($sformatf("tab%0d rom_address", i), 32'(rom_address), 32'(tab[i].e_addr));
      chk($sformatf("tab%0d rom_sel", i), 32'(rom_sel), 32'(tab[i].e_sel));
      cycle(0, 0, 0);
      chk($sformatf("tab%0d pix_valid", i), 32'(pix_valid), 32'(tab[i].e_pv));
      chk($sformatf("tab%0d pix_index", i), 32'(pix_index), 32'(tab[i].e_idx));
      chk($sformatf("tab%0d blank_out", i), 32'(blank_out), 32'(tab[i].bl));
    end

    // Priority: s0 and s2 both cover (200,200)
    cfg(0, 195, 190, 1); frame();
    cycle(200, 200, 1);
    chk("prio rom_sel", 32'(rom_sel), 0);
    chk("prio rom_address", 32'(rom_address), 205);
    cycle(0, 0, 0);
    chk("prio pix_sprite", 32'(pix_sprite), 0);
    chk("prio pix_valid", 32'(pix_valid), 1);
    cfg(0, 195, 190, 0); frame();
    cycle(200, 200, 1);
    chk("s0 off rom_sel", 32'(rom_sel), 2);
    cycle(0, 0, 0);
    chk("s0 off pix_sprite", 32'(pix_sprite), 2);

    // Transparent winner hides s2 behind it; blank=0 suppresses an opaque pixel
    rom_mem[0][205] = 8'h00;
    cfg(0, 195, 190, 1); frame();
    cycle(200, 200, 1); cycle(0, 0, 0);
    chk("transparent pix_valid", 32'(pix_valid), 0);
    rom_mem[0][205] = 8'h05;
    cycle(200, 200, 0); cycle(0, 0, 0);
    chk("blank0 pix_valid", 32'(pix_valid), 0);
    chk("blank0 blank_out", 32'(blank_out), 0);

    // Mid-frame move of s1 is deferred; a write on the frame_start cycle waits one more frame
    cfg(1, 400, 400, 1);
    cycle(305, 301, 1);
    chk("mid old rom_sel", 32'(rom_sel), 1);
    cycle(405, 401, 1);
    chk("mid new addr", 32'(rom_address), 0);
    cycle(0, 0, 0, 1, 1, 1, 500, 500, 1);
    cycle(405, 401, 1);
    chk("moved rom_sel", 32'(rom_sel), 1);
    chk("moved addr", 32'(rom_address), 25);
    cycle(505, 501, 1);
    chk("deferred addr", 32'(rom_address), 0);
    frame();
    cycle(505, 501, 1);
    chk("deferred applied addr", 32'(rom_address), 25);

    // Collision: s0 and s3 overlap only at (119,69)
    cfg(0, 100, 50, 1); cfg(3, 119, 69, 1); frame(); frame();
    chk("coll idle", 32'(collision), 0);
    cycle(119, 69, 1); frame();
    chk("coll set", 32'(collision), 1);
    cycle(119, 69, 0); frame();
    chk("coll clear", 32'(collision), 0);

    // Clipping at the right edge
    cfg(3, 1015, 400, 1); frame();
    cycle(1021, 400, 1);
    chk("clip addr", 32'(rom_address), 6);
    cycle(3, 400, 1);
    chk("nowrap sel", 32'(rom_sel), 0);
    chk("nowrap addr", 32'(rom_address), 0);

    // Asynchronous reset mid-stream
    cycle(105, 52, 1); cycle(105, 52, 1);
    #3 reset_n = 0;
    #1;
    chk("areset rom_address", 32'(rom_address), 0);
    chk("areset rom_sel", 32'(rom_sel), 0);
    chk("areset pix_valid", 32'(pix_valid), 0);
    chk("areset pix_index", 32'(pix_index), 0);
    chk("areset pix_sprite", 32'(pix_sprite), 0);
    chk("areset blank_out", 32'(blank_out), 0);
    chk("areset collision", 32'(collision), 0);
    model_reset();
    @(posedge vga_clk); @(posedge vga_clk);
    #3 reset_n = 1;
    cycle(105, 52, 1);
    chk("post reset disabled", 32'(rom_address), 0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      int k, px, py, wx, wy;
      bit we, fs, bl;
      k  = $urandom_range(0, 3);
      px = (m_sh_x[k] + $urandom_range(0, 26) - 3) & 1023;
      py = (m_sh_y[k] + $urandom_range(0, 26) - 3) & 1023;
      bl = $urandom_range(0, 3) != 0;
      fs = $urandom_range(0, 63) == 0;
      we = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 1) == 1) begin
        wx = $urandom_range(0, 60); wy = $urandom_range(0, 60);
      end else begin
        wx = $urandom_range(980, 1023); wy = $urandom_range(0, 500);
      end
      cycle(px, py, bl, fs, we, $urandom_range(0, 3), wx, wy, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
